// File: rtl/spi_slave_regs_pkg.sv
// spi_slave_regs shared definitions.
// Frame geometry and FSM state encoding.
package spi_slave_regs_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS   = 8;
  localparam int DATA_BITS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WAIT_END
  } state_e;

endpackage

// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs board SPI pins.
// Master drives sen/sclk/mosi, slave drives miso/miso_oe.
interface spi_slave_regs_if;

  logic sen;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sen,
    output sclk,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sen,
    input  sclk,
    input  mosi,
    output miso,
    output miso_oe
  );

endinterface

// File: rtl/spi_slave_regs_sync.sv
// spi_slave_sync: 2-flop synchronizer plus one delay
// stage for rise/fall detection of an async pin.
module spi_slave_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Metastability chain and edge-history stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: oversampled SPI responder serving
// a bank of 16-bit registers via 24-bit frames.
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_slave_regs_if.slave          spi,
  output logic                     wr_stb,
  output logic [6:0]               wr_addr,
  output logic [15:0]              wr_data,
  output logic [16*NUM_REGS-1:0]   regs_flat,
  output logic                     busy,
  output logic                     frame_err
);

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_sen_rise;
  logic        w_sen_fall;
  logic        w_commit;
  logic        w_end;
  logic [15:0] w_shift_nx;
  logic [15:0] w_rd;

  logic        r_mosi_s1;
  logic        r_mosi_s2;
  state_e      r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic        r_rw;
  logic [6:0]  r_addr;
  logic [15:0] r_tx;
  logic [4:0]  r_txcnt;
  logic        r_miso;
  logic        r_oe;
  logic        r_busy;
  logic        r_ferr;
  logic        r_wr_stb;
  logic [6:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic [15:0] r_regs [NUM_REGS];

  // sclk idles low; sen syncs reset low so that a
  // frame already in flight at reset never looks
  // like a fresh sen fall.
  spi_slave_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi.sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_slave_sync #(.RST_VAL(1'b0)) u_sen_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi.sen),
    .o_rise (w_sen_rise),
    .o_fall (w_sen_fall)
  );

  // mosi only needs the 2-flop synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_mosi_s1 <= spi.mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_shift_nx = {r_shift[14:0], r_mosi_s2};
  assign w_end      = w_sen_rise && (r_state != ST_IDLE);
  assign w_commit   = w_end && !r_rw
                   && (r_cnt == 5'(FRAME_BITS));

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_addr == 7'(k)) w_rd = r_regs[k];
    end
  end

  // Frame FSM with registered pin and strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_tx      <= '0;
      r_txcnt   <= '0;
      r_miso    <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      r_ferr   <= 1'b0;
      if (w_end) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_oe    <= 1'b0;
        r_miso  <= 1'b0;
        if (r_cnt == 5'(FRAME_BITS)) begin
          if (!r_rw) begin
            r_wr_stb  <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= r_shift;
          end
        end else begin
          r_ferr <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_sen_fall) begin
              r_state <= ST_CMD;
              r_cnt   <= '0;
              r_shift <= '0;
              r_txcnt <= '0;
              r_busy  <= 1'b1;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_nx;
              r_cnt   <= r_cnt + 5'd1;
              if (r_cnt == 5'(CMD_BITS - 1)) begin
                r_rw    <= w_shift_nx[7];
                r_addr  <= w_shift_nx[6:0];
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_nx;
              r_cnt   <= r_cnt + 5'd1;
              if (r_cnt == 5'(FRAME_BITS - 1))
                r_state <= ST_WAIT_END;
            end
          end
          ST_WAIT_END: begin
            if (w_sclk_rise && r_cnt != 5'd31)
              r_cnt <= r_cnt + 5'd1;
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_sclk_fall && r_rw
            && (r_state == ST_DATA
             || r_state == ST_WAIT_END)) begin
          if (r_txcnt == 5'd0) begin
            r_oe    <= 1'b1;
            r_miso  <= w_rd[15];
            r_tx    <= {w_rd[14:0], 1'b0};
            r_txcnt <= 5'd1;
          end else if (r_txcnt < 5'(DATA_BITS)) begin
            r_miso  <= r_tx[15];
            r_tx    <= {r_tx[14:0], 1'b0};
            r_txcnt <= r_txcnt + 5'd1;
          end else begin
            r_oe   <= 1'b0;
            r_miso <= 1'b0;
          end
        end
      end
    end
  end

  // Register bank; writes land with wr_stb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++)
        r_regs[k] <= RESET_VAL;
    end else if (w_commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_addr == 7'(k)) r_regs[k] <= r_shift;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[16*g +: 16] = r_regs[g];
  end

  assign spi.miso    = r_miso;
  assign spi.miso_oe = r_oe;
  assign wr_stb      = r_wr_stb;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign frame_err   = r_ferr;

endmodule
